// File: rtl/dso_trig_capture.sv
// dso_trig_capture: circular-buffer write-address and trigger controller for the DSO sample RAM.
// Define DSO_AUTO_TRIG_EN to add the auto-trigger timeout (trig_forced is otherwise tied low).
module dso_trig_capture #(
  parameter int AW = 9,
  parameter int TO_W = 16,
  parameter int AUTO_TO = 65535
) (
  input  logic          clk_cnt,
  input  logic          rst,
  input  logic          arm,
  input  logic          abort,
  input  logic          cont,
  input  logic          edge_sel,
  input  logic          auto_en,
  input  logic [AW-1:0] pre_len,
  input  logic          trig_in,
  output logic [AW-1:0] wraddr,
  output logic          wr_en,
  output logic [AW-1:0] start_addr,
  output logic [AW-1:0] trig_addr,
  output logic          done,
  output logic          cnt_irq,
  output logic          trig_forced
);
  typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} state_t;
  localparam logic [AW-1:0] P_MAX = '1;
  state_t state, nxt;
  logic [AW-1:0] p;
  logic [2:0] sync;
  logic irq_q, trig_edge, forced, trig, start;
  // sync[1] is the synchronised pin, sync[2] its previous value
  assign trig_edge = edge_sel ? (sync[2] & ~sync[1]) : (~sync[2] & sync[1]);
  assign trig = state == WAIT && (trig_edge || forced);
  assign start = !abort && ((state == IDLE && arm) || (state == DONE && (arm || cont)));
  always_ff @(posedge clk_cnt or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = start ? (pre_len == '0 ? WAIT : PRE) : state;
      PRE:        nxt = wraddr == p - AW'(1) ? WAIT : PRE;
      WAIT:       nxt = trig ? (p == P_MAX ? DONE : POST) : WAIT;
      POST:       nxt = wraddr == start_addr - AW'(1) ? DONE : POST;
      default:    nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  always_comb begin
    wr_en = state == PRE || state == WAIT || state == POST;
    done = state == DONE;
    cnt_irq = irq_q;
  end
  always_ff @(posedge clk_cnt or posedge rst)
    if (rst) begin
      sync <= '0;
      wraddr <= '0;
      p <= '0;
      start_addr <= '0;
      trig_addr <= '0;
      irq_q <= 1'b0;
    end else begin
      sync <= {sync[1:0], trig_in};
      irq_q <= nxt == DONE && state != DONE;
      if (start) begin
        wraddr <= '0;
        p <= pre_len;
      end else if (wr_en && !abort) wraddr <= wraddr + AW'(1);
      // the oldest sample sits p writes before the trigger sample
      if (trig && !abort) begin
        trig_addr <= wraddr;
        start_addr <= wraddr - p;
      end
    end
`ifdef DSO_AUTO_TRIG_EN
  logic [TO_W-1:0] to_cnt;
  assign forced = auto_en && to_cnt == TO_W'(AUTO_TO) && !trig_edge;
  always_ff @(posedge clk_cnt or posedge rst)
    if (rst) begin
      to_cnt <= '0;
      trig_forced <= 1'b0;
    end else begin
      if (state != WAIT) to_cnt <= '0;
      else if (auto_en) to_cnt <= to_cnt + TO_W'(1);
      if (start) trig_forced <= 1'b0;
      else if (trig && !abort) trig_forced <= forced;
    end
`else
  logic [TO_W:0] unused_cfg;
  assign unused_cfg = {auto_en, TO_W'(AUTO_TO)};
  assign forced = 1'b0;
  assign trig_forced = 1'b0;
`endif
endmodule

// File: tb/tb_dso_trig_capture.sv
// tb_dso_trig_capture: scoreboard bench for dso_trig_capture (AW=4, AUTO_TO=20).
module tb_dso_trig_capture;
  localparam int AW = 4;
  typedef struct {int trig; int start; int nw; int last; int forced;} rec_t;
  logic clk_cnt = 0, rst = 1, arm = 0, abort = 0, cont = 0, edge_sel = 0, auto_en = 0, trig_in = 0;
  logic [AW-1:0] pre_len = '0;
  logic [AW-1:0] wraddr, start_addr, trig_addr;
  logic wr_en, done, cnt_irq, trig_forced;
  int n_tests = 0, n_fail = 0, n_irq = 0, nw = 0, irq0 = 0;
  logic [AW-1:0] last_wr = '0;
  rec_t sb[$];
  rec_t e;
  dso_trig_capture #(.AW(AW), .TO_W(8), .AUTO_TO(20)) dut (
    .clk_cnt(clk_cnt), .rst(rst), .arm(arm), .abort(abort), .cont(cont),
    .edge_sel(edge_sel), .auto_en(auto_en), .pre_len(pre_len), .trig_in(trig_in),
    .wraddr(wraddr), .wr_en(wr_en), .start_addr(start_addr), .trig_addr(trig_addr),
    .done(done), .cnt_irq(cnt_irq), .trig_forced(trig_forced)
  );
  always #5 clk_cnt = ~clk_cnt;
  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_cnt);
    #1;
  endtask
  // records complete on cnt_irq: compare against the oldest expected record
  always @(negedge clk_cnt) begin
    if (rst) nw = 0;
    else if (cnt_irq) begin
      n_irq++;
      if (sb.size() == 0) chk("irq_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        chk("trig_addr", trig_addr, e.trig);
        chk("start_addr", start_addr, e.start);
        chk("writes", nw, e.nw);
        chk("last_wr", last_wr, e.last);
        chk("trig_forced", trig_forced, e.forced);
        chk("done_lvl", done, 1);
        chk("wr_en_done", wr_en, 0);
      end
      nw = 0;
    end else if (wr_en) begin
      nw++;
      last_wr = wraddr;
    end else nw = 0;
  end
  // arm with pre-trigger p and make the edge land in WAIT cycle j
  task automatic start_rec(input int p, input int j, input logic act, input bit push);
    int n = p + j - 1;
    if (push) sb.push_back('{(p + j) % 16, j % 16, j + 16, (j + 15) % 16, 0});
    pre_len = AW'(p);
    arm = 1;
    if (n == 0) trig_in = act;
    tick;
    arm = 0;
    if (n >= 1) begin
      repeat (n - 1) tick;
      trig_in = act;
    end
  endtask
  task automatic wait_done(input string tag);
    int i = 0;
    while (!done && i < 300) begin
      tick;
      i++;
    end
    chk(tag, done, 1);
  endtask
  initial begin
    repeat (2) tick;
    rst = 0;
    tick;
    chk("rst_wraddr", wraddr, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_irq", cnt_irq, 0);
    chk("rst_start", start_addr, 0);
    chk("rst_trig", trig_addr, 0);
    chk("rst_forced", trig_forced, 0);
    start_rec(4, 6, 1, 1);
    wait_done("t1_done");
    repeat (3) tick;
    chk("t1_hold_done", done, 1);
    chk("t1_hold_wr", wr_en, 0);
    chk("t1_irq_pulse", cnt_irq, 0);
    trig_in = 1;
    edge_sel = 1;
    repeat (4) tick;
    start_rec(0, 7, 0, 1);
    wait_done("t2_done");
    edge_sel = 0;
    repeat (4) tick;
    start_rec(15, 2, 1, 1);
    wait_done("t3_done");
    trig_in = 0;
    repeat (4) tick;
    start_rec(4, 2, 1, 0);
    repeat (5) tick;
    chk("t4_pre_abort_wr", wr_en, 1);
    irq0 = n_irq;
    pre_len = 3;
    arm = 1;
    abort = 1;
    tick;
    arm = 0;
    abort = 0;
    chk("t4_abort_wr", wr_en, 0);
    chk("t4_abort_done", done, 0);
    chk("t4_abort_irq", cnt_irq, 0);
    chk("t4_trig_held", trig_addr, 6);
    trig_in = 0;
    repeat (20) tick;
    chk("t4_no_irq", n_irq - irq0, 0);
    arm = 1;
    tick;
    arm = 0;
    chk("t4_rearm_wr", wr_en, 1);
    chk("t4_rearm_addr0", wraddr, 0);
    tick;
    chk("t4_rearm_addr1", wraddr, 1);
    abort = 1;
    tick;
    abort = 0;
    chk("t4_abort2_wr", wr_en, 0);
    cont = 1;
    irq0 = n_irq;
    start_rec(0, 3, 1, 1);
    repeat (5) tick;
    trig_in = 0;
    repeat (17) tick;
    trig_in = 1;
    sb.push_back('{5, 5, 21, 4, 0});
    repeat (5) tick;
    trig_in = 0;
    repeat (14) tick;
    trig_in = 1;
    sb.push_back('{2, 2, 18, 1, 0});
    repeat (30) tick;
    chk("t5_cont_irqs", n_irq - irq0, 3);
    cont = 0;
    trig_in = 0;
    repeat (5) tick;
    trig_in = 1;
    repeat (6) tick;
    chk("t5_pre_rst_wr", wr_en, 1);
    irq0 = n_irq;
    rst = 1;
    #1;
    chk("t5_rst_wraddr", wraddr, 0);
    chk("t5_rst_wr_en", wr_en, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_irq", cnt_irq, 0);
    chk("t5_rst_start", start_addr, 0);
    chk("t5_rst_trig", trig_addr, 0);
    #2;
    rst = 0;
    trig_in = 0;
    repeat (20) tick;
    chk("t5_rst_no_irq", n_irq - irq0, 0);
    auto_en = 1;
    pre_len = 2;
`ifdef DSO_AUTO_TRIG_EN
    sb.push_back('{6, 4, 36, 3, 1});
    arm = 1;
    tick;
    arm = 0;
    wait_done("t6_auto_done");
    chk("t6_forced_lvl", trig_forced, 1);
    pre_len = 0;
    arm = 1;
    tick;
    arm = 0;
    chk("t6_forced_clr", trig_forced, 0);
`else
    arm = 1;
    tick;
    arm = 0;
    repeat (60) tick;
    chk("t6_still_wait_wr", wr_en, 1);
    chk("t6_still_wait_done", done, 0);
    chk("t6_forced_tied", trig_forced, 0);
`endif
    abort = 1;
    tick;
    abort = 0;
    tick;
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
